// File: rtl/kvadd2_pkg.sv
// Shared types and constants for the kvadd2 kernel control sequencer.
package kvadd2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned ENG_A   = 0;
  localparam int unsigned ENG_B   = 1;
  localparam int unsigned ENG_RES = 2;

  localparam int unsigned RUN_CNT_W            = 32;
  localparam int unsigned KV_TIMEOUT_CYCLES_DEF = 32'd16777216;

endpackage

// File: rtl/kvadd2_done_collector.sv
// Sticky engine-done vector, all-done detect and saturating launch-to-done cycle counter.
module kvadd2_done_collector
  import kvadd2_pkg::*;
#(
  parameter int unsigned C_NUM_ENG        = 3,
  parameter int unsigned C_TIMEOUT_CYCLES = KV_TIMEOUT_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 run_en,
  input  logic [C_NUM_ENG-1:0] eng_done,
  output logic                 all_done_c,
  output logic                 tmo_hit_c,
  output logic [RUN_CNT_W-1:0] run_cycles
);

  // The timeout fires in the RUN cycle whose increment brings the count to C_TIMEOUT_CYCLES-1.
  localparam logic [RUN_CNT_W-1:0] TMO_LAST = RUN_CNT_W'(C_TIMEOUT_CYCLES - 32'd2);

  logic [C_NUM_ENG-1:0] done_q, done_d, merged;
  logic [RUN_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    merged     = done_q | eng_done;
    all_done_c = run_en && (&merged);
    tmo_hit_c  = run_en && (cnt_q == TMO_LAST);
    done_d     = done_q;
    cnt_d      = cnt_q;
    if (clear) begin
      done_d = '0;
      cnt_d  = '0;
    end else if (run_en) begin
      done_d = merged;
      if (cnt_q != '1) cnt_d = cnt_q + RUN_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= '0;
      cnt_q  <= '0;
    end else begin
      done_q <= done_d;
      cnt_q  <= cnt_d;
    end
  end

  assign run_cycles = cnt_q;

endmodule

// File: rtl/kvadd2_ctrl_seq.sv
// kvadd2 kernel sequencer: ap_ctrl_chain handshake, engine launch, done collection, watchdog.
module kvadd2_ctrl_seq
  import kvadd2_pkg::*;
#(
  parameter int unsigned C_NUM_ENG         = 3,
  parameter int unsigned C_XFER_SIZE_WIDTH = 32,
  parameter int unsigned C_TIMEOUT_CYCLES  = KV_TIMEOUT_CYCLES_DEF
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         ap_start,
  input  logic                         ap_continue,
  output logic                         ap_idle,
  output logic                         ap_ready,
  output logic                         ap_done,
  input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_length,
  output logic [C_NUM_ENG-1:0]         eng_start,
  input  logic [C_NUM_ENG-1:0]         eng_done,
  output logic [C_XFER_SIZE_WIDTH-1:0] eng_xfer_size,
  output logic                         err_timeout,
  output logic [31:0]                  run_cycles
);

  // Reset asserts asynchronously and releases two clocks after ap_rst_n deasserts.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) rst_sync_q <= 2'b00;
    else           rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  state_t                         state_q, state_d;
  logic [C_XFER_SIZE_WIDTH-1:0]   xfer_q, xfer_d;
  logic                           err_q, err_d;
  logic                           idle_q, idle_d;
  logic                           ready_q, ready_d;
  logic                           done_q, done_d;
  logic [C_NUM_ENG-1:0]           start_q, start_d;
  logic                           clr;
  logic                           run_en;
  logic                           all_done_c;
  logic                           tmo_hit_c;

  kvadd2_done_collector #(
    .C_NUM_ENG       (C_NUM_ENG),
    .C_TIMEOUT_CYCLES(C_TIMEOUT_CYCLES)
  ) u_collect (
    .clk       (ap_clk),
    .rst_n     (rst_n),
    .clear     (clr),
    .run_en    (run_en),
    .eng_done  (eng_done),
    .all_done_c(all_done_c),
    .tmo_hit_c (tmo_hit_c),
    .run_cycles(run_cycles)
  );

  // Next state; outputs are precomputed from the next state so they appear registered.
  always_comb begin
    state_d = state_q;
    xfer_d  = xfer_q;
    err_d   = err_q;
    clr     = 1'b0;
    run_en  = 1'b0;
    start_d = '0;
    case (state_q)
      IDLE: begin
        if (ap_start) begin
          state_d = LAUNCH;
          xfer_d  = ctrl_length;
          err_d   = 1'b0;
          clr     = 1'b1;
          if (ctrl_length != '0) start_d = '1;
        end
      end
      LAUNCH: state_d = (xfer_q == '0) ? DONE : RUN;
      RUN: begin
        run_en = 1'b1;
        if (all_done_c) begin
          state_d = DONE;
        end else if (tmo_hit_c) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      DONE: if (ap_continue) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    idle_d  = (state_d == IDLE);
    ready_d = (state_d == LAUNCH);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge ap_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      xfer_q  <= '0;
      err_q   <= 1'b0;
      idle_q  <= 1'b1;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      start_q <= '0;
    end else begin
      state_q <= state_d;
      xfer_q  <= xfer_d;
      err_q   <= err_d;
      idle_q  <= idle_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      start_q <= start_d;
    end
  end

  assign ap_idle       = idle_q;
  assign ap_ready      = ready_q;
  assign ap_done       = done_q;
  assign eng_start     = start_q;
  assign eng_xfer_size = xfer_q;
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_kvadd2_ctrl_seq.sv
// Directed bench for kvadd2_ctrl_seq: vector table of full runs plus hand-written corner sequences.
module tb_kvadd2_ctrl_seq;

  localparam int unsigned NE  = 3;
  localparam int unsigned W   = 32;
  localparam int unsigned TMO = 64;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          ap_start = 1'b0;
  logic          ap_continue = 1'b0;
  logic          ap_idle, ap_ready, ap_done;
  logic [W-1:0]  ctrl_length = '0;
  logic [NE-1:0] eng_start;
  logic [NE-1:0] eng_done = '0;
  logic [W-1:0]  eng_xfer_size;
  logic          err_timeout;
  logic [31:0]   run_cycles;

  int total = 0;
  int bad   = 0;

  always #5 ap_clk = ~ap_clk;

  kvadd2_ctrl_seq #(
    .C_NUM_ENG        (NE),
    .C_XFER_SIZE_WIDTH(W),
    .C_TIMEOUT_CYCLES (TMO)
  ) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .ap_start     (ap_start),
    .ap_continue  (ap_continue),
    .ap_idle      (ap_idle),
    .ap_ready     (ap_ready),
    .ap_done      (ap_done),
    .ctrl_length  (ctrl_length),
    .eng_start    (eng_start),
    .eng_done     (eng_done),
    .eng_xfer_size(eng_xfer_size),
    .err_timeout  (err_timeout),
    .run_cycles   (run_cycles)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Engine offsets are cycles after LAUNCH at which each engine pulses done; 0 = never.
  typedef struct {
    logic [31:0] len;
    int          off_a;
    int          off_b;
    int          off_r;
    int          exp_done;
    logic        exp_err;
    logic [31:0] exp_cyc;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v);
    int done_k;
    @(negedge ap_clk);
    ap_start    = 1'b1;
    ctrl_length = v.len;
    @(negedge ap_clk);
    ap_start    = 1'b0;
    ctrl_length = ~v.len;
    chk("launch_idle", 64'(ap_idle), 64'd0);
    chk("launch_ready", 64'(ap_ready), 64'd1);
    chk("launch_start", 64'(eng_start), 64'h7);
    chk("launch_xfer", 64'(eng_xfer_size), 64'(v.len));
    chk("launch_rc_clr", 64'(run_cycles), 64'd0);
    chk("launch_err_clr", 64'(err_timeout), 64'd0);
    done_k = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge ap_clk);
      eng_done = '0;
      chk("run_start_low", 64'(eng_start), 64'd0);
      chk("run_xfer_stable", 64'(eng_xfer_size), 64'(v.len));
      if (ap_done) begin
        done_k = k;
        break;
      end
      eng_done[0] = (v.off_a == k);
      eng_done[1] = (v.off_b == k);
      eng_done[2] = (v.off_r == k);
    end
    eng_done = '0;
    chk("done_latency", 64'(done_k), 64'(v.exp_done));
    chk("err_timeout", 64'(err_timeout), 64'(v.exp_err));
    chk("run_cycles", 64'(run_cycles), 64'(v.exp_cyc));
    repeat (2) begin
      @(negedge ap_clk);
      chk("done_hold", 64'(ap_done), 64'd1);
      chk("rc_hold", 64'(run_cycles), 64'(v.exp_cyc));
    end
    ap_continue = 1'b1;
    @(negedge ap_clk);
    ap_continue = 1'b0;
    chk("cont_idle", 64'(ap_idle), 64'd1);
    chk("cont_done_low", 64'(ap_done), 64'd0);
    chk("cont_err_kept", 64'(err_timeout), 64'(v.exp_err));
  endtask

  initial begin
    vecs[0] = '{32'd16384, 10, 20, 35, 36, 1'b0, 32'd35};
    vecs[1] = '{32'd100, 5, 5, 5, 6, 1'b0, 32'd5};
    vecs[2] = '{32'd64, 10, 20, 0, 64, 1'b1, 32'd63};
    vecs[3] = '{32'd8, 63, 63, 63, 64, 1'b0, 32'd63};
    vecs[4] = '{32'd1, 1, 1, 1, 2, 1'b0, 32'd1};
    vecs[5] = '{32'hFFFF_FFFF, 62, 0, 62, 64, 1'b1, 32'd63};
    vecs[6] = '{32'd33, 62, 30, 63, 64, 1'b0, 32'd63};
    vecs[7] = '{32'd12, 63, 63, 0, 64, 1'b1, 32'd63};

    // Reset values
    repeat (3) @(negedge ap_clk);
    chk("rst_idle", 64'(ap_idle), 64'd1);
    chk("rst_ready", 64'(ap_ready), 64'd0);
    chk("rst_done", 64'(ap_done), 64'd0);
    chk("rst_start", 64'(eng_start), 64'd0);
    chk("rst_xfer", 64'(eng_xfer_size), 64'd0);
    chk("rst_err", 64'(err_timeout), 64'd0);
    chk("rst_rc", 64'(run_cycles), 64'd0);
    ap_rst_n = 1'b1;
    repeat (4) @(negedge ap_clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Zero length: no engine launch, done two cycles after the accept cycle
    @(negedge ap_clk);
    ap_start    = 1'b1;
    ctrl_length = '0;
    @(negedge ap_clk);
    ap_start = 1'b0;
    eng_done = '1;
    chk("z_ready", 64'(ap_ready), 64'd1);
    chk("z_start", 64'(eng_start), 64'd0);
    chk("z_idle", 64'(ap_idle), 64'd0);
    chk("z_done_early", 64'(ap_done), 64'd0);
    @(negedge ap_clk);
    eng_done = '0;
    chk("z_done", 64'(ap_done), 64'd1);
    chk("z_ready_low", 64'(ap_ready), 64'd0);
    chk("z_err", 64'(err_timeout), 64'd0);
    chk("z_rc", 64'(run_cycles), 64'd0);
    repeat (3) begin
      @(negedge ap_clk);
      chk("z_hold", 64'(ap_done), 64'd1);
    end
    ap_continue = 1'b1;
    @(negedge ap_clk);
    ap_continue = 1'b0;
    chk("z_idle_after", 64'(ap_idle), 64'd1);
    chk("z_done_after", 64'(ap_done), 64'd0);

    // Back-to-back with ap_start held high
    @(negedge ap_clk);
    ap_start    = 1'b1;
    ctrl_length = 32'd2048;
    @(negedge ap_clk);
    chk("b1_ready", 64'(ap_ready), 64'd1);
    chk("b1_xfer", 64'(eng_xfer_size), 64'd2048);
    repeat (2) @(negedge ap_clk);
    @(negedge ap_clk);
    eng_done = '1;
    @(negedge ap_clk);
    eng_done = '0;
    chk("b1_done", 64'(ap_done), 64'd1);
    chk("b1_rc", 64'(run_cycles), 64'd3);
    ctrl_length = 32'd4096;
    ap_continue = 1'b1;
    @(negedge ap_clk);
    ap_continue = 1'b0;
    chk("b2_idle", 64'(ap_idle), 64'd1);
    chk("b2_done_low", 64'(ap_done), 64'd0);
    @(negedge ap_clk);
    ap_start = 1'b0;
    chk("b2_launch_idle", 64'(ap_idle), 64'd0);
    chk("b2_ready", 64'(ap_ready), 64'd1);
    chk("b2_start", 64'(eng_start), 64'h7);
    chk("b2_xfer", 64'(eng_xfer_size), 64'd4096);
    chk("b2_rc_clr", 64'(run_cycles), 64'd0);
    @(negedge ap_clk);
    eng_done    = 3'b011;
    ap_continue = 1'b1;
    @(negedge ap_clk);
    eng_done    = '0;
    ap_continue = 1'b0;
    chk("b2_partial", 64'(ap_done), 64'd0);
    repeat (2) begin
      @(negedge ap_clk);
      chk("b2_wait", 64'(ap_done), 64'd0);
    end
    @(negedge ap_clk);
    eng_done = 3'b100;
    @(negedge ap_clk);
    eng_done = '0;
    chk("b2_done", 64'(ap_done), 64'd1);
    chk("b2_rc", 64'(run_cycles), 64'd5);
    chk("b2_err", 64'(err_timeout), 64'd0);
    ap_continue = 1'b1;
    @(negedge ap_clk);
    ap_continue = 1'b0;
    chk("b2_idle_after", 64'(ap_idle), 64'd1);

    // Reset asserted mid-RUN
    @(negedge ap_clk);
    ap_start    = 1'b1;
    ctrl_length = 32'd50;
    @(negedge ap_clk);
    ap_start = 1'b0;
    repeat (10) @(negedge ap_clk);
    chk("mr_running", 64'(run_cycles), 64'd9);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("mr_idle", 64'(ap_idle), 64'd1);
    chk("mr_ready", 64'(ap_ready), 64'd0);
    chk("mr_done", 64'(ap_done), 64'd0);
    chk("mr_start", 64'(eng_start), 64'd0);
    chk("mr_xfer", 64'(eng_xfer_size), 64'd0);
    chk("mr_err", 64'(err_timeout), 64'd0);
    chk("mr_rc", 64'(run_cycles), 64'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (4) @(negedge ap_clk);
    eng_done = '1;
    @(negedge ap_clk);
    eng_done = '0;
    repeat (3) begin
      @(negedge ap_clk);
      chk("mr_spurious_done", 64'(ap_done), 64'd0);
      chk("mr_spurious_idle", 64'(ap_idle), 64'd1);
    end

    run_vec(vecs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
